// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Central stall/flush sequencer for the five-stage Mach-V pipeline.
//   Resolves load-use hazards, branch mispredictions, multi-cycle (MUL/DIV)
//   execution and data-memory wait states, and keeps two saturating
//   performance counters.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-low reset
//   MemtoRegE, RdE        E-stage load flag and destination register
//   Rs1D, Rs2D            D-stage source registers
//   MispredictE           branch in E resolved against its prediction
//   MCycleStartE          E-stage instruction is MUL/DIV
//   MCycleDone            multi-cycle result valid
//   MemStallM             data memory not ready in M
//   CntClr                synchronous clear of both counters
//   StallF..StallW        hold the stage register
//   FlushD, FlushE, FlushM load a bubble into the stage register
//   MCycleGoE             start strobe to the multi-cycle unit
//   StallCnt, FlushCnt    saturating event counters
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemtoRegE,
    input  logic [4:0]  RdE,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        MispredictE,
    input  logic        MCycleStartE,
    input  logic        MCycleDone,
    input  logic        MemStallM,
    input  logic        CntClr,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MCycleGoE,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

    state_t state, state_nxt;
    logic   load_use;
    logic   flush_take;   // mispredict flush actually applied this cycle

    assign load_use = MemtoRegE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state logic; a memory freeze holds everything, including a
    // pending start or a Done pulse (the unit keeps Done high until seen).
    always_comb begin
        state_nxt = state;
        if (!MemStallM) begin
            case (state)
                RUN:     if (MCycleStartE) state_nxt = MC_BUSY;
                MC_BUSY: if (MCycleDone)   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        MCycleGoE  = 1'b0;
        flush_take = 1'b0;
        if (!RESET) begin
            // Fill the pipe with bubbles while held in reset.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (MemStallM) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else begin
            case (state)
                MC_BUSY: begin
                    // On Done everything releases and the result moves to M.
                    if (!MCycleDone) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: begin
                    if (MCycleStartE) begin
                        MCycleGoE = 1'b1;
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                    end else if (MispredictE) begin
                        // D holds a wrong-path instruction, so a coincident
                        // load-use is irrelevant.
                        FlushD     = 1'b1;
                        FlushE     = 1'b1;
                        flush_take = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating counters; clear beats increment.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            StallCnt <= 16'd0;
            FlushCnt <= 16'd0;
        end else if (CntClr) begin
            StallCnt <= 16'd0;
            FlushCnt <= 16'd0;
        end else begin
            if (StallF && (StallCnt != 16'hFFFF))     StallCnt <= StallCnt + 16'd1;
            if (flush_take && (FlushCnt != 16'hFFFF)) FlushCnt <= FlushCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MemtoRegE = 1'b0, MispredictE = 1'b0, MCycleStartE = 1'b0;
    logic        MCycleDone = 1'b0, MemStallM = 1'b0, CntClr = 1'b0;
    logic [4:0]  RdE = 5'd0, Rs1D = 5'd0, Rs2D = 5'd0;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushD, FlushE, FlushM, MCycleGoE;
    logic [15:0] StallCnt, FlushCnt;

    hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET), .MemtoRegE(MemtoRegE), .RdE(RdE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .MispredictE(MispredictE),
        .MCycleStartE(MCycleStartE), .MCycleDone(MCycleDone),
        .MemStallM(MemStallM), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MCycleGoE(MCycleGoE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rst_n, mtr, misp, start, done, mems, clr;
        logic [4:0] rde, rs1, rs2;
    } stim_t;

    // ctl = {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushM,GoE}
    typedef struct packed {
        logic [8:0]  ctl;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: is a MUL/DIV occupying E, plus the two counts.
    bit busy = 0;
    int m_sc = 0, m_fc = 0;

    // Apply one cycle of stimulus, predict the response, advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit sf, sd, se, sm, sw, fd, fe, fm, go, lu, took;
        @(posedge CLK); #1;
        RESET = s.rst_n; MemtoRegE = s.mtr; RdE = s.rde; Rs1D = s.rs1;
        Rs2D = s.rs2; MispredictE = s.misp; MCycleStartE = s.start;
        MCycleDone = s.done; MemStallM = s.mems; CntClr = s.clr;
        {sf, sd, se, sm, sw, fd, fe, fm, go, took} = '0;
        lu = s.mtr && s.rde != 0 && (s.rde == s.rs1 || s.rde == s.rs2);
        if (!s.rst_n) begin
            busy = 0; m_sc = 0; m_fc = 0;
            {fd, fe, fm} = 3'b111;
        end else if (s.mems) {sf, sd, se, sm, sw} = 5'b11111;
        else if (busy && !s.done) {sf, sd, se, fm} = 4'b1111;
        else if (busy) ;
        else if (s.start) {go, sf, sd, se, fm} = 5'b11111;
        else if (s.misp) {fd, fe, took} = 3'b111;
        else if (lu) {sf, sd, fe} = 3'b111;
        e.ctl = {sf, sd, se, sm, sw, fd, fe, fm, go};
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        q.push_back(e);
        if (s.rst_n) begin
            if (s.clr) begin m_sc = 0; m_fc = 0; end
            else begin
                if (sf && m_sc < 65535) m_sc++;
                if (took && m_fc < 65535) m_fc++;
            end
            if (!s.mems) begin
                if (busy && s.done) busy = 0;
                else if (!busy && s.start) busy = 1;
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Monitor: outputs are combinational, compare mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, MCycleGoE} !== e.ctl) begin
                errors++;
                $display("FAIL ctl @%0t got=%b exp=%b", $time,
                    {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, MCycleGoE}, e.ctl);
            end
            checks++;
            if (StallCnt !== e.sc) begin
                errors++;
                $display("FAIL StallCnt @%0t got=%h exp=%h", $time, StallCnt, e.sc);
            end
            checks++;
            if (FlushCnt !== e.fc) begin
                errors++;
                $display("FAIL FlushCnt @%0t got=%h exp=%h", $time, FlushCnt, e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        s = '0; step(s); step(s);                     // reset state
        s = idle(); step(s);

        // Load-use on Rs2, then clear; same with RdE=0.
        s = idle(); s.mtr = 1; s.rde = 5; s.rs1 = 3; s.rs2 = 5; step(s);
        s = idle(); s.rs1 = 3; s.rs2 = 5; step(s);
        s = idle(); s.mtr = 1; s.rde = 0; s.rs1 = 0; s.rs2 = 0; step(s);

        // Mispredict with coincident load-use.
        s = idle(); s.mtr = 1; s.rde = 7; s.rs1 = 7; s.misp = 1; step(s);
        s = idle(); step(s);

        // MUL: Done four cycles after start.
        s = idle(); s.start = 1; step(s);
        s.misp = 1; s.mtr = 1; s.rde = 2; s.rs1 = 2;   // ignored while busy
        repeat (3) step(s);
        s = idle(); s.done = 1; step(s);
        s = idle(); step(s);

        // Memory freeze mid-MUL with Done held.
        s = idle(); s.start = 1; step(s);
        s = idle(); step(s);
        s = idle(); s.done = 1; s.mems = 1; repeat (3) step(s);
        s.mems = 0; step(s);
        s = idle(); step(s);

        // Start deferred under a freeze.
        s = idle(); s.start = 1; s.mems = 1; repeat (2) step(s);
        s.mems = 0; step(s);
        s = idle(); s.done = 1; step(s);

        // Reset mid-MUL.
        s = idle(); s.start = 1; step(s);
        s = idle(); step(s);
        s = '0; s.start = 1; step(s);
        s = idle(); step(s);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.mtr   = ($urandom_range(0, 2) == 0);
            s.rde   = 5'($urandom_range(0, 3));
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.misp  = ($urandom_range(0, 5) == 0);
            s.start = ($urandom_range(0, 9) == 0);
            s.done  = ($urandom_range(0, 3) == 0);
            s.mems  = ($urandom_range(0, 4) == 0);
            s.clr   = ($urandom_range(0, 199) == 0);
            s.rst_n = ($urandom_range(0, 499) != 0);
            step(s);
        end

        // Saturation: long MUL stall drives StallCnt past 16'hFFFF.
        s = idle(); s.clr = 1; step(s);
        s = idle(); s.start = 1; step(s);
        for (int i = 0; i < 65540; i++) begin
            s = idle();
            s.mems = ($urandom_range(0, 7) == 0);
            s.misp = ($urandom_range(0, 3) == 0);
            step(s);
        end
        s = idle(); s.clr = 1; step(s);               // clear while StallF=1
        s = idle(); step(s);
        s = idle(); s.done = 1; step(s);
        s = idle(); step(s);

        @(posedge CLK); @(negedge CLK); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush sequencer for the five-stage Mach-V pipeline. It resolves load-use hazards, branch mispredictions, multi-cycle (MUL/DIV) execution and data-memory wait states. From these it drives the Stall*/Flush* controls of the F/D/E/M/W pipeline registers and gates the start of the multi-cycle unit. Two saturating event counters support performance analysis.

## Interface
- No parameters; all widths fixed at 32-bit datapath, 5-bit register indices, 16-bit counters.
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- MemtoRegE  in  1  instruction in E is a load
- RdE  in  5  destination register of E
- Rs1D, Rs2D  in  5 each  source registers of D
- MispredictE  in  1  branch resolved in E disagrees with prediction (PrPCSrcE/PrBTAE)
- MCycleStartE  in  1  instruction in E is MUL/DIV
- MCycleDone  in  1  multi-cycle unit result valid (one-cycle pulse)
- MemStallM  in  1  data memory not ready for access in M
- CntClr  in  1  synchronous clear of both counters
- StallF, StallD, StallE, StallM, StallW  out  1 each  hold the stage register
- FlushD, FlushE, FlushM  out  1 each  load bubble into the stage register
- MCycleGoE  out  1  start strobe to the multi-cycle unit
- StallCnt  out  16  cycles with StallF=1, saturating
- FlushCnt  out  16  mispredict flushes taken, saturating

## Operation
- FSM states: RUN, MC_BUSY. Counters are the only other state. All control outputs are combinational from state plus inputs.
- Priority, applied per cycle, highest first:
  - MemStallM=1: all five Stall*=1, all Flush*=0. FSM state held. MCycleGoE=0.
  - MC_BUSY, MCycleDone=0: StallF/D/E=1, FlushM=1; other controls 0. MispredictE and load-use ignored. MCycleStartE ignored, since the instruction is still held in E.
  - MC_BUSY, MCycleDone=1: all Stall*=0, all Flush*=0. The result advances to M. Next state RUN.
  - RUN, MCycleStartE=1: MCycleGoE=1, StallF/D/E=1, FlushM=1. Next state MC_BUSY.
  - RUN, MispredictE=1: FlushD=1, FlushE=1, no stalls. This takes precedence over a coincident load-use, because D holds a wrong-path instruction.
  - RUN, load-use: MemtoRegE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D). Response: StallF=1, StallD=1, FlushE=1.
  - Otherwise all controls 0.
- MispredictE and MCycleStartE are never both 1; they describe the same E instruction. If both are 1 anyway, MCycleStartE wins.
- MCycleDone while in RUN is ignored.
- Counters:
  - StallCnt +1 in each cycle StallF=1.
  - FlushCnt +1 in each cycle the MispredictE flush is applied.
  - Both hold at 16'hFFFF.
  - CntClr=1 loads 0; this overrides any increment that cycle.

## Timing
- Reset (RESET=0, async) forces state RUN and StallCnt=FlushCnt=0.
- While RESET=0: all Stall*=0, FlushD/E/M=1, MCycleGoE=0.
- First active edge after RESET rises: normal RUN behaviour.
- Load-use costs exactly 1 bubble. Next cycle the load is in M, the hazard term clears and D proceeds.
- Mispredict costs 2 bubbles (D and E).
- MUL/DIV: cycle 0 MCycleGoE=1. Stalls hold from cycle 0 through the cycle before MCycleDone. The Done cycle releases. Total occupancy of E = 1 + cycles until Done.
- MemStallM mid-MC_BUSY: freeze wins. If MCycleDone pulses during the freeze it is lost. The multi-cycle unit's contract is therefore: Done is re-asserted (held) until a non-frozen cycle. Verification checks Done level-holding under MemStallM.
- MemStallM coincident with MCycleStartE in RUN: start deferred. MCycleGoE=0, state stays RUN, start retried when MemStallM falls.
- RESET asserted mid-MC_BUSY: immediate return to RUN. The multi-cycle unit is reset by the same signal.

## Test plan
- Load x5 in E, D reads x5 as Rs2 -> one cycle StallF=StallD=1, FlushE=1; next cycle all 0. Same with RdE=0 -> no stall.
- MispredictE=1 with coincident load-use -> FlushD=FlushE=1, StallF=0; FlushCnt 0->1.
- MCycleStartE=1 in RUN, MCycleDone pulses 4 cycles later -> MCycleGoE high only cycle 0. StallF/D/E=1 and FlushM=1 on cycles 0-3. Cycle 4 all 0, state RUN. StallCnt=4.
- MemStallM=1 for 3 cycles during MC_BUSY, Done held high across them -> all Stall*=1 for 3 cycles, then release on first unfrozen Done cycle.
- Assert RESET low during MC_BUSY -> outputs immediately Flush*=1, Stall*=0. After release, state RUN and counters 0.
- Preload StallCnt to 16'hFFFE via a long MUL stall -> saturates at 16'hFFFF. CntClr with StallF=1 -> 0.
